// File: rtl/axi_lite_s.sv
`default_nettype none
// ============================================================================
// Module   : axi_lite_s
// Brief    : AXI4-Lite slave register file with byte-strobe writes, SLVERR on
//            out-of-range accesses and a saturating error-response counter.
// Revision : 1.0 - initial release
// ============================================================================
module axi_lite_s #(
  parameter int                      AXI_ADDR_WIDTH      = 32,
  parameter int                      AXI_DATA_WIDTH      = 32,
  parameter int                      REG_NUM             = 16,
  parameter logic [AXI_ADDR_WIDTH-1:0] AXI_SLAVE_ADDR_BASE = 32'h4000_0000
) (
  input  logic                        i_axi_lite_clk,
  input  logic                        i_axi_lite_rstn,
  input  logic [AXI_ADDR_WIDTH-1:0]   i_axi_awaddr,
  input  logic [2:0]                  i_axi_awprot,
  input  logic                        i_axi_awvalid,
  output logic                        o_axi_awready,
  input  logic [AXI_DATA_WIDTH-1:0]   i_axi_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0] i_axi_wstrb,
  input  logic                        i_axi_wvalid,
  output logic                        o_axi_wready,
  output logic [1:0]                  o_axi_bresp,
  output logic                        o_axi_bvalid,
  input  logic                        i_axi_bready,
  input  logic [AXI_ADDR_WIDTH-1:0]   i_axi_araddr,
  input  logic [2:0]                  i_axi_arprot,
  input  logic                        i_axi_arvalid,
  output logic                        o_axi_arready,
  output logic [AXI_DATA_WIDTH-1:0]   o_axi_rdata,
  output logic [1:0]                  o_axi_rresp,
  output logic                        o_axi_rvalid,
  input  logic                        i_axi_rready,
  output logic [15:0]                 o_err_count
);

  localparam int                        STRB_W = AXI_DATA_WIDTH / 8;
  localparam int                        IDX_W  = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;
  localparam logic [AXI_ADDR_WIDTH-1:0] SPAN   = AXI_ADDR_WIDTH'(4 * REG_NUM);
  localparam logic [1:0]                OKAY   = 2'b00;
  localparam logic [1:0]                SLVERR = 2'b10;

  typedef enum logic [1:0] {
    WR_IDLE    = 2'd0,
    WR_HAVE_AW = 2'd1,
    WR_HAVE_W  = 2'd2,
    WR_RESP    = 2'd3
  } wr_state_t;

  typedef enum logic [0:0] {
    RD_IDLE = 1'b0,
    RD_RESP = 1'b1
  } rd_state_t;

  wr_state_t wr_state, wr_next;
  rd_state_t rd_state, rd_next;

  logic [AXI_DATA_WIDTH-1:0] regs [REG_NUM];
  logic [AXI_ADDR_WIDTH-1:0] aw_addr_q;
  logic [AXI_DATA_WIDTH-1:0] w_data_q;
  logic [STRB_W-1:0]         w_strb_q;

  logic aw_hs, w_hs, ar_hs;
  logic commit, aw_latch, w_latch, b_done;

  logic [AXI_ADDR_WIDTH-1:0] wr_addr, wr_off, rd_off;
  logic [AXI_DATA_WIDTH-1:0] wr_data;
  logic [STRB_W-1:0]         wr_strb;
  logic                      wr_hit, rd_hit;
  logic [IDX_W-1:0]          wr_idx, rd_idx;
  logic                      wr_err, rd_err;
  logic [16:0]               err_sum;

  // Protection bits carry no meaning for this register file.
  logic unused_prot;
  assign unused_prot = ^{i_axi_awprot, i_axi_arprot};

  assign aw_hs = i_axi_awvalid && o_axi_awready;
  assign w_hs  = i_axi_wvalid  && o_axi_wready;
  assign ar_hs = i_axi_arvalid && o_axi_arready;

  // Commit uses the held beat for whichever channel arrived first, live bus otherwise.
  assign wr_addr = (wr_state == WR_HAVE_AW) ? aw_addr_q : i_axi_awaddr;
  assign wr_data = (wr_state == WR_HAVE_W)  ? w_data_q  : i_axi_wdata;
  assign wr_strb = (wr_state == WR_HAVE_W)  ? w_strb_q  : i_axi_wstrb;

  // Offset compare avoids overflow of BASE + span near the top of the map.
  assign wr_off = wr_addr - AXI_SLAVE_ADDR_BASE;
  assign wr_hit = (wr_addr >= AXI_SLAVE_ADDR_BASE) && (wr_off < SPAN);
  assign wr_idx = wr_off[IDX_W+1:2];
  assign rd_off = i_axi_araddr - AXI_SLAVE_ADDR_BASE;
  assign rd_hit = (i_axi_araddr >= AXI_SLAVE_ADDR_BASE) && (rd_off < SPAN);
  assign rd_idx = rd_off[IDX_W+1:2];

  assign wr_err = commit && !wr_hit;
  assign rd_err = ar_hs  && !rd_hit;

  // Write FSM state register.
  always_ff @(posedge i_axi_lite_clk or negedge i_axi_lite_rstn) begin
    if (!i_axi_lite_rstn) wr_state <= WR_IDLE;
    else                  wr_state <= wr_next;
  end

  // Write FSM next state: gather AW and W in either order, commit when both are in.
  always_comb begin
    wr_next  = wr_state;
    commit   = 1'b0;
    aw_latch = 1'b0;
    w_latch  = 1'b0;
    b_done   = 1'b0;
    case (wr_state)
      WR_IDLE: begin
        if (aw_hs && w_hs) begin
          commit  = 1'b1;
          wr_next = WR_RESP;
        end else if (aw_hs) begin
          aw_latch = 1'b1;
          wr_next  = WR_HAVE_AW;
        end else if (w_hs) begin
          w_latch = 1'b1;
          wr_next = WR_HAVE_W;
        end
      end
      WR_HAVE_AW: if (w_hs) begin
        commit  = 1'b1;
        wr_next = WR_RESP;
      end
      WR_HAVE_W: if (aw_hs) begin
        commit  = 1'b1;
        wr_next = WR_RESP;
      end
      WR_RESP: if (o_axi_bvalid && i_axi_bready) begin
        b_done  = 1'b1;
        wr_next = WR_IDLE;
      end
      default: wr_next = WR_IDLE;
    endcase
  end

  // Registered write-channel handshakes, holding registers and response.
  always_ff @(posedge i_axi_lite_clk or negedge i_axi_lite_rstn) begin
    if (!i_axi_lite_rstn) begin
      o_axi_awready <= 1'b0;
      o_axi_wready  <= 1'b0;
      o_axi_bvalid  <= 1'b0;
      o_axi_bresp   <= OKAY;
      aw_addr_q     <= '0;
      w_data_q      <= '0;
      w_strb_q      <= '0;
    end else begin
      o_axi_awready <= (wr_next == WR_IDLE) || (wr_next == WR_HAVE_W);
      o_axi_wready  <= (wr_next == WR_IDLE) || (wr_next == WR_HAVE_AW);
      if (aw_latch) aw_addr_q <= i_axi_awaddr;
      if (w_latch) begin
        w_data_q <= i_axi_wdata;
        w_strb_q <= i_axi_wstrb;
      end
      if (commit) begin
        o_axi_bvalid <= 1'b1;
        o_axi_bresp  <= wr_hit ? OKAY : SLVERR;
      end else if (b_done) begin
        o_axi_bvalid <= 1'b0;
      end
    end
  end

  // Register file: strobed byte update on an in-range commit.
  always_ff @(posedge i_axi_lite_clk or negedge i_axi_lite_rstn) begin
    if (!i_axi_lite_rstn) begin
      for (int r = 0; r < REG_NUM; r++) regs[r] <= '0;
    end else if (commit && wr_hit) begin
      for (int k = 0; k < STRB_W; k++) begin
        if (wr_strb[k]) regs[wr_idx][8*k +: 8] <= wr_data[8*k +: 8];
      end
    end
  end

  // Read FSM state register.
  always_ff @(posedge i_axi_lite_clk or negedge i_axi_lite_rstn) begin
    if (!i_axi_lite_rstn) rd_state <= RD_IDLE;
    else                  rd_state <= rd_next;
  end

  // Read FSM next state: one outstanding read at a time.
  always_comb begin
    rd_next = rd_state;
    case (rd_state)
      RD_IDLE: if (ar_hs) rd_next = RD_RESP;
      RD_RESP: if (o_axi_rvalid && i_axi_rready) rd_next = RD_IDLE;
      default: rd_next = RD_IDLE;
    endcase
  end

  // Registered read channel; the array is sampled before any same-edge write lands.
  always_ff @(posedge i_axi_lite_clk or negedge i_axi_lite_rstn) begin
    if (!i_axi_lite_rstn) begin
      o_axi_arready <= 1'b0;
      o_axi_rvalid  <= 1'b0;
      o_axi_rresp   <= OKAY;
      o_axi_rdata   <= '0;
    end else begin
      o_axi_arready <= (rd_next == RD_IDLE);
      if (ar_hs) begin
        o_axi_rvalid <= 1'b1;
        o_axi_rresp  <= rd_hit ? OKAY : SLVERR;
        o_axi_rdata  <= rd_hit ? regs[rd_idx] : '0;
      end else if (o_axi_rvalid && i_axi_rready) begin
        o_axi_rvalid <= 1'b0;
      end
    end
  end

  assign err_sum = {1'b0, o_err_count} + 17'(wr_err) + 17'(rd_err);

  // Saturating count of SLVERR responses, both channels.
  always_ff @(posedge i_axi_lite_clk or negedge i_axi_lite_rstn) begin
    if (!i_axi_lite_rstn) o_err_count <= '0;
    else                  o_err_count <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
  end

endmodule
`default_nettype wire
